// File: rtl/timer_defs.sv
// Shared definitions for the memory-mapped down-counting timer: register map,
// CTRL bit positions and controller state encoding.
package timer_defs;

  localparam logic [1:0] TIMER_CTRL   = 2'd0;
  localparam logic [1:0] TIMER_PRESET = 2'd1;
  localparam logic [1:0] TIMER_COUNT  = 2'd2;

  localparam int unsigned CTRL_EN       = 0;
  localparam int unsigned CTRL_MODE_LSB = 1;
  localparam int unsigned CTRL_IM       = 3;

  localparam logic [1:0] MODE_ONESHOT = 2'b00;
  localparam logic [1:0] MODE_AUTO    = 2'b01;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_CNT,
    S_INT
  } state_e;

endpackage

// File: rtl/timer_dev.sv
// Programmable 32-bit down-counting timer with one-shot and auto-reload modes;
// irq feeds one CP0 HWInt bit.
module timer_dev
  import timer_defs::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  addr,
  input  logic        we,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic        irq
);

  logic [3:0]  ctrl_q, ctrl_d;
  logic [31:0] preset_q, preset_d;
  logic [31:0] count_q, count_d;
  logic        flag_q, flag_d;
  state_e      state_q, state_d;

  logic ctrl_wr, preset_wr;

  assign ctrl_wr   = we && (addr == TIMER_CTRL);
  assign preset_wr = we && (addr == TIMER_PRESET);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_q   <= '0;
      preset_q <= '0;
      count_q  <= '0;
      flag_q   <= 1'b0;
      state_q  <= S_IDLE;
    end else begin
      ctrl_q   <= ctrl_d;
      preset_q <= preset_d;
      count_q  <= count_d;
      flag_q   <= flag_d;
      state_q  <= state_d;
    end
  end

  always_comb begin
    ctrl_d   = ctrl_q;
    preset_d = preset_q;
    count_d  = count_q;
    flag_d   = flag_q;
    state_d  = state_q;

    // A CTRL/PRESET store acknowledges the interrupt; a terminal count below overrides it.
    if (ctrl_wr || preset_wr) flag_d = 1'b0;
    if (preset_wr) preset_d = din;

    case (state_q)
      S_IDLE: begin
        if (ctrl_q[CTRL_EN]) state_d = S_LOAD;
      end
      S_LOAD: begin
        count_d = preset_q;
        state_d = S_CNT;
      end
      S_CNT: begin
        if (!ctrl_q[CTRL_EN]) begin
          state_d = S_IDLE;
        end else if (count_q > 32'd1) begin
          count_d = count_q - 32'd1;
        end else begin
          // Treats PRESET = 0 like 1 and never wraps below zero.
          count_d = '0;
          flag_d  = 1'b1;
          state_d = S_INT;
        end
      end
      S_INT: begin
        if (ctrl_q[CTRL_MODE_LSB +: 2] == MODE_AUTO) begin
          flag_d  = 1'b0;
          state_d = S_LOAD;
        end else begin
          ctrl_d[CTRL_EN] = 1'b0;
          state_d         = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Placed last so a software CTRL store beats the one-shot EN clear.
    if (ctrl_wr) ctrl_d = din[3:0];
  end

  always_comb begin
    dout = '0;
    case (addr)
      TIMER_CTRL:   dout = {28'd0, ctrl_q};
      TIMER_PRESET: dout = preset_q;
      TIMER_COUNT:  dout = count_q;
      default:      dout = '0;
    endcase
  end

  assign irq = ctrl_q[CTRL_IM] & flag_q;

endmodule

// File: tb/tb_timer_dev.sv
// Scoreboard bench for timer_dev: a timeline model predicts dout/irq each cycle,
// a negedge monitor compares.
module tb_timer_dev;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  addr;
  logic        we;
  logic [31:0] din;
  logic [31:0] dout;
  logic        irq;

  timer_dev dut (
    .clk  (clk),
    .rst  (rst),
    .addr (addr),
    .we   (we),
    .din  (din),
    .dout (dout),
    .irq  (irq)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  typedef struct {
    logic [1:0]  a;
    logic [31:0] d;
    logic        i;
  } exp_t;
  exp_t sb[$];

  // Model: m_k counts edges since the timer was armed (-1 = idle); m_n is the
  // effective preset captured at load.
  logic [3:0]  m_ctrl;
  logic [31:0] m_preset;
  logic [31:0] m_count;
  logic        m_flag;
  int          m_k;
  longint      m_n;

  logic        cur_we;
  logic [1:0]  cur_addr;
  logic [31:0] cur_din;

  function automatic void model_reset();
    m_ctrl   = '0;
    m_preset = '0;
    m_count  = '0;
    m_flag   = 1'b0;
    m_k      = -1;
    m_n      = 1;
  endfunction

  function automatic void model_step(input logic w, input logic [1:0] a, input logic [31:0] d);
    logic [3:0] c;
    logic       f;
    logic       set_f;
    int         k;
    c     = m_ctrl;
    f     = m_flag;
    set_f = 1'b0;
    if (m_k < 0) begin
      if (m_ctrl[0]) m_k = 0;
    end else begin
      k = m_k + 1;
      if (k == 1) begin
        m_count = m_preset;
        m_n     = (m_preset == 32'd0) ? 64'd1 : longint'(m_preset);
        m_k     = 1;
      end else if (k <= m_n + 1) begin
        if (!m_ctrl[0]) m_k = -1;
        else if (k == m_n + 1) begin
          m_count = '0;
          set_f   = 1'b1;
          m_k     = k;
        end else begin
          m_count = 32'(m_n - longint'(k - 1));
          m_k     = k;
        end
      end else begin
        if (m_ctrl[2:1] == 2'b01) begin
          f   = 1'b0;
          m_k = 0;
        end else begin
          c[0] = 1'b0;
          m_k  = -1;
        end
      end
    end
    if (w && a == 2'd0) begin
      c = d[3:0];
      f = 1'b0;
    end
    if (w && a == 2'd1) begin
      m_preset = d;
      f        = 1'b0;
    end
    if (set_f) f = 1'b1;
    m_ctrl = c;
    m_flag = f;
  endfunction

  function automatic logic [31:0] model_read(input logic [1:0] a);
    case (a)
      2'd0:    return {28'd0, m_ctrl};
      2'd1:    return m_preset;
      2'd2:    return m_count;
      default: return 32'd0;
    endcase
  endfunction

  // One clock: update the model for the edge just taken, then drive the next bus cycle.
  task automatic tick(input logic w, input logic [1:0] a, input logic [31:0] d, input logic r);
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    if (rst) model_reset();
    else model_step(cur_we, cur_addr, cur_din);
    rst = r;
    if (r) model_reset();
    we       = r ? 1'b0 : w;
    addr     = a;
    din      = d;
    cur_we   = we;
    cur_addr = a;
    cur_din  = d;
    e.a = a;
    e.d = model_read(a);
    e.i = m_ctrl[3] & m_flag;
    sb.push_back(e);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    tick(1'b1, a, d, 1'b0);
  endtask

  task automatic rd(input logic [1:0] a, input int n);
    repeat (n) tick(1'b0, a, 32'd0, 1'b0);
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      n_tests++;
      if (dout !== e.d || irq !== e.i) begin
        n_fail++;
        $display("FAIL cycle %0d addr=%0d: dout=%h irq=%b, required dout=%h irq=%b",
                 cyc, e.a, dout, irq, e.d, e.i);
      end
    end
  end

  initial begin
    logic [31:0] rv;
    logic [31:0] rd_data;
    rst      = 1'b1;
    we       = 1'b0;
    addr     = 2'd0;
    din      = '0;
    cur_we   = 1'b0;
    cur_addr = 2'd0;
    cur_din  = '0;
    model_reset();
    tick(1'b0, 2'd0, 32'd0, 1'b1);
    tick(1'b0, 2'd1, 32'd0, 1'b1);
    tick(1'b0, 2'd2, 32'd0, 1'b0);
    rd(2'd3, 1);

    // Reset in the middle of a long count.
    wr(2'd1, 32'd100);
    wr(2'd0, 32'h1);
    rd(2'd2, 20);
    tick(1'b0, 2'd2, 32'd0, 1'b1);
    tick(1'b0, 2'd0, 32'd0, 1'b1);
    tick(1'b0, 2'd2, 32'd0, 1'b0);
    rd(2'd2, 5);
    rd(2'd0, 1);

    // One-shot, PRESET=5; then acknowledge with a PRESET write.
    wr(2'd1, 32'd5);
    wr(2'd0, 32'h9);
    rd(2'd2, 10);
    rd(2'd0, 2);
    wr(2'd1, 32'd5);
    rd(2'd0, 2);

    // Auto-reload, PRESET=3.
    wr(2'd1, 32'd3);
    wr(2'd0, 32'hB);
    rd(2'd2, 16);
    wr(2'd0, 32'h0);
    rd(2'd2, 3);

    // Interrupt masked.
    wr(2'd0, 32'h1);
    wr(2'd1, 32'd2);
    rd(2'd2, 8);
    wr(2'd0, 32'h8);
    rd(2'd0, 3);

    // Disable mid-count, then re-enable.
    wr(2'd1, 32'd10);
    wr(2'd0, 32'h1);
    rd(2'd2, 4);
    wr(2'd0, 32'h0);
    rd(2'd2, 4);
    wr(2'd0, 32'h1);
    rd(2'd2, 14);
    wr(2'd0, 32'h0);

    // PRESET=0 one-shot; stores to COUNT and the unused slot.
    wr(2'd0, 32'h8);
    wr(2'd1, 32'd0);
    wr(2'd0, 32'h9);
    rd(2'd0, 5);
    wr(2'd2, 32'hDEAD_BEEF);
    wr(2'd3, 32'hCAFE_F00D);
    for (int a = 0; a < 4; a++) rd(2'(a), 1);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      rv = $urandom();
      rd_data = $urandom();
      case ($urandom_range(0, 99))
        0, 1, 2, 3:    wr(2'd0, rv);
        4, 5, 6, 7:    wr(2'd1, 32'($urandom_range(0, 6)));
        8, 9:          wr({1'b1, rv[0]}, rd_data);
        10: begin
          tick(1'b0, rv[1:0], 32'd0, 1'b1);
          tick(1'b0, rv[3:2], 32'd0, 1'b0);
        end
        default:       rd(rv[1:0], 1);
      endcase
    end

    rd(2'd0, 1);
    @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard drain: %0d entries left, required 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/timer_dev.md
# timer_dev

Programmable 32-bit down-counting timer on the CPU's memory-mapped device bus. Its `irq` output drives one bit of the coprocessor-0 `HWInt[5:0]` vector, making it the interrupt source directly upstream of CP0. It supports two modes, one-shot and auto-reload. Software writes `PRESET`/`CTRL` through the bus bridge (`sw`) and reads `COUNT` back (`lw`).

## Interface
- No parameters; widths are fixed by the 32-bit datapath.
- `clk` input 1: system clock, rising edge.
- `rst` input 1: reset, asynchronous, active-high.
- `addr` input 2: word address within the device (bus address bits [3:2]).
- `we` input 1: write strobe, one cycle per store.
- `din` input 32: write data.
- `dout` output 32: read data, combinational from `addr`.
- `irq` output 1: interrupt request to CP0 `HWInt` bit, registered.

## Operation
- **Register map:**
  - `addr`=0 is `CTRL`. Only bits [3:0] are implemented; [31:4] read 0.
  - `addr`=1 is `PRESET` (32 b).
  - `addr`=2 is `COUNT` (32 b, read-only; writes are ignored).
  - `addr`=3 reads 0 and ignores writes.
- **`CTRL` bits:**
  - [0] EN: count enable.
  - [2:1] MODE: 00 = one-shot, 01 = auto-reload, 10/11 behave as one-shot.
  - [3] IM: interrupt mask, 1 = enabled.
- **`irq` output:** `irq` = IM & `int_flag`, registered.
- **State machine:** four states, IDLE, LOAD, CNT, INT.
  - IDLE: if EN, go to LOAD; otherwise stay.
  - LOAD: `COUNT` <= `PRESET`; go to CNT.
  - CNT:
    - If !EN, go to IDLE. `COUNT` holds its value.
    - Else if `COUNT` > 1, decrement `COUNT`.
    - Else `COUNT` <= 0, `int_flag` <= 1, and go to INT.
  - INT, one-shot: EN <= 0; go to IDLE. `int_flag` stays 1.
  - INT, auto-reload: `int_flag` <= 0; go to LOAD. This makes `irq` a one-cycle pulse.
- **`int_flag` clear:** a bus write to `CTRL` or `PRESET` clears `int_flag`. This is how software acknowledges a one-shot interrupt.
- **Arithmetic:** unsigned; `COUNT` never wraps below 0.
- **`PRESET` = 0:** behaves identically to `PRESET` = 1.
- **Writing `PRESET` mid-count:** does not disturb `COUNT`; the new value takes effect at the next LOAD.
- **Simultaneous events:**
  - A bus write to `CTRL` in the same cycle as the INT-state EN clear: the bus write wins.
  - A `CTRL`/`PRESET` write in the same cycle as `int_flag` being set in CNT: the set wins.
- **Reset:** `CTRL`, `PRESET`, `COUNT` = 0; state IDLE; `int_flag` = 0. Therefore `irq` = 0 and `dout` = 0 for every `addr`.
- **Reset mid-count:** abandons the count immediately; no interrupt is issued.

## Timing
- Register writes take effect at the rising edge on which `we` is sampled high.
- **One-shot latency:** let the edge of the `CTRL` write setting EN be E0.
  - E1: IDLE -> LOAD.
  - E2: `COUNT` = N, state CNT.
  - E(N+1): `COUNT` = 1.
  - E(N+2): `COUNT` = 0, `int_flag` = 1.
  - `irq` is high from E(N+2) when IM = 1.
- **Auto-reload:** `irq` pulses one cycle every N+2 cycles.
- **Clearing EN mid-count:** state is IDLE one edge after the write; `COUNT` is frozen at its current value.
- `dout` is valid in the same cycle as `addr`; there are no read side effects.

## Structure
- **Shared package/header `timer_defs`:**
  - address constants `TIMER_CTRL`, `TIMER_PRESET`, `TIMER_COUNT`;
  - `CTRL` bit positions EN/MODE/IM;
  - state encodings `S_IDLE`, `S_LOAD`, `S_CNT`, `S_INT`.
- Single module, no sub-module. Keep one sequential process for registers + FSM, and separate combinational logic for `dout`/`irq`.

## Test plan
- Reset asserted mid-count (`PRESET`=100, EN=1, after 20 cycles) -> `COUNT`=0, `CTRL`=0, `irq`=0, state IDLE; stays IDLE after release.
- `PRESET`=5, then `CTRL`=0x9 (EN, one-shot, IM) -> `irq` rises exactly 7 edges after the `CTRL` write, stays high, `CTRL` reads 0x8. A `PRESET` write then drops `irq` next cycle.
- `PRESET`=3, `CTRL`=0xB (auto-reload, IM) -> `irq` one-cycle pulses with period 5, first 5 edges after the write. `COUNT` sequence reads 3,2,1,0,-,3,...
- `CTRL`=0x1 (IM=0), `PRESET`=2 -> count completes, `int_flag` set internally, `irq` stays 0. A subsequent write of `CTRL`=0x8 clears `int_flag`; `irq` stays 0.
- `PRESET`=10, EN=1; after 4 cycles write `CTRL`=0 -> `COUNT` frozen at the value it held at the write edge minus at most one decrement. Re-enable -> reload from `PRESET`=10.
- `PRESET`=0, one-shot -> behaves as `PRESET`=1: `irq` 3 edges after enable. Writes to `addr` 2/3 leave all registers unchanged.
